bn_nibble_serial_adder: RTL and testbench

//   Multi-cycle N-bit adder that feeds the 4-bit CLA slice (b4_cla_block) one nibble per clock.
//   The carry is registered between nibbles, so one 4-bit slice replaces N/4 chained slices.

---
 rtl/bn_nibble_serial_adder.sv | 125 ++++++++++++
 tb/tb_bn_nibble_serial_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bn_nibble_serial_adder.sv
// Multi-cycle N-bit adder: one 4-bit carry-lookahead slice is reused once per nibble,
// with the inter-nibble carry held in a register. Valid/ready handshakes on both sides.
module bn_nibble_serial_adder #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         C_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         C_out,
  output logic         overflow
);

  localparam int unsigned Nibbles = N / 4;
  localparam int unsigned KW      = (Nibbles > 1) ? $clog2(Nibbles) : 1;
  localparam logic [KW-1:0] KLast = KW'(Nibbles - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  z_q, z_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;

  // Nibble k lives at bit offset 4k.
  logic [KW+1:0] bit_idx;
  assign bit_idx = {k_q, 2'b00};

  // 4-bit carry-lookahead slice.
  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_sum;
  logic [4:0] nib_c;

  always_comb begin
    nib_a    = x_q[bit_idx +: 4];
    nib_b    = y_q[bit_idx +: 4];
    nib_g    = nib_a & nib_b;
    nib_p    = nib_a ^ nib_b;
    nib_c[0] = carry_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & nib_c[0]);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
    nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
    nib_sum  = nib_p ^ nib_c[3:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          x_d     = X;
          y_d     = Y;
          carry_d = C_in;
          k_d     = '0;
        end
      end
      StRun: begin
        z_d[bit_idx +: 4] = nib_sum;
        carry_d           = nib_c[4];
        k_d               = k_q + KW'(1);
        if (k_q == KLast) begin
          // Only the top nibble's carries define the word-level flags.
          c_out_d = nib_c[4];
          ovf_d   = nib_c[3] ^ nib_c[4];
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Z         = z_q;
  assign C_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bn_nibble_serial_adder.sv
// Bench for bn_nibble_serial_adder: directed corner cases at N=16 and randomized adds at
// N=4 and N=32, all checked against an arithmetic reference model.
module tb_bn_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Index 0: N=4, 1: N=16, 2: N=32.
  logic        iv4, ir4, ovl4, or4, ci4, co4, of4;
  logic [3:0]  x4, y4, z4;
  logic        iv16, ir16, ovl16, or16, ci16, co16, of16;
  logic [15:0] x16, y16, z16;
  logic        iv32, ir32, ovl32, or32, ci32, co32, of32;
  logic [31:0] x32, y32, z32;

  bn_nibble_serial_adder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .X(x4), .Y(y4), .C_in(ci4),
    .out_valid(ovl4), .out_ready(or4), .Z(z4), .C_out(co4), .overflow(of4)
  );
  bn_nibble_serial_adder #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .X(x16), .Y(y16), .C_in(ci16),
    .out_valid(ovl16), .out_ready(or16), .Z(z16), .C_out(co16), .overflow(of16)
  );
  bn_nibble_serial_adder #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .X(x32), .Y(y32), .C_in(ci32),
    .out_valid(ovl32), .out_ready(or32), .Z(z32), .C_out(co32), .overflow(of32)
  );

  function automatic int width_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 32;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(int d, logic iv, logic [31:0] x, logic [31:0] y, logic ci);
    case (d)
      0: begin iv4 = iv; x4 = x[3:0]; y4 = y[3:0]; ci4 = ci; end
      1: begin iv16 = iv; x16 = x[15:0]; y16 = y[15:0]; ci16 = ci; end
      default: begin iv32 = iv; x32 = x; y32 = y; ci32 = ci; end
    endcase
  endtask

  task automatic set_oready(int d, logic r);
    case (d)
      0: or4 = r;
      1: or16 = r;
      default: or32 = r;
    endcase
  endtask

  task automatic peek(int d, output logic [31:0] z, output logic ir, output logic ov,
                      output logic co, output logic of);
    case (d)
      0: begin z = {28'b0, z4}; ir = ir4; ov = ovl4; co = co4; of = of4; end
      1: begin z = {16'b0, z16}; ir = ir16; ov = ovl16; co = co16; of = of16; end
      default: begin z = z32; ir = ir32; ov = ovl32; co = co32; of = of32; end
    endcase
  endtask

  // Reference: unsigned sum for Z/C_out, signed range test for overflow.
  task automatic model(int w, logic [31:0] x, logic [31:0] y, logic ci,
                       output logic [31:0] ez, output logic eco, output logic eof);
    longint mask = (longint'(1) <<< w) - 1;
    longint ux   = longint'(x) & mask;
    longint uy   = longint'(y) & mask;
    longint s    = ux + uy + longint'(ci);
    longint half = longint'(1) <<< (w - 1);
    longint sx   = (ux >= half) ? ux - (mask + 1) : ux;
    longint sy   = (uy >= half) ? uy - (mask + 1) : uy;
    longint ss   = sx + sy + longint'(ci);
    ez  = 32'(s & mask);
    eco = ((s >>> w) & 1) != 0;
    eof = (ss > half - 1) || (ss < -half);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, DUT idle.
  task automatic run_add(int d, logic [31:0] x, logic [31:0] y, logic ci, int gap, int hold,
                         string tag);
    logic [31:0] z, ez;
    logic ir, ov, co, of, eco, eof;
    int cyc;
    int w = width_of(d);
    model(w, x, y, ci, ez, eco, eof);
    set_oready(d, 1'b0);
    repeat (gap) begin
      drive_in(d, 1'b0, $urandom, $urandom, 1'($urandom));
      @(negedge clk);
    end
    drive_in(d, 1'b1, x, y, ci);
    peek(d, z, ir, ov, co, of);
    check({tag, ".in_ready_idle"}, 64'(ir), 64'(1));
    @(negedge clk);
    // Scramble the inputs to show they are ignored after acceptance.
    drive_in(d, 1'b0, $urandom, $urandom, 1'($urandom));
    cyc = 0;
    peek(d, z, ir, ov, co, of);
    while (!ov && cyc < 64) begin
      @(negedge clk);
      cyc++;
      peek(d, z, ir, ov, co, of);
    end
    check({tag, ".latency"}, 64'(cyc), 64'(w / 4));
    check({tag, ".Z"}, 64'(z), 64'(ez));
    check({tag, ".C_out"}, 64'(co), 64'(eco));
    check({tag, ".overflow"}, 64'(of), 64'(eof));
    repeat (hold) begin
      drive_in(d, 1'b1, $urandom, $urandom, 1'($urandom));
      @(negedge clk);
      peek(d, z, ir, ov, co, of);
      check({tag, ".hold_state"}, {61'b0, ov, ir, co}, {61'b0, 1'b1, 1'b0, eco});
      check({tag, ".hold_Z"}, 64'(z), 64'(ez));
      check({tag, ".hold_ovf"}, 64'(of), 64'(eof));
    end
    drive_in(d, 1'b0, 32'b0, 32'b0, 1'b0);
    set_oready(d, 1'b1);
    @(negedge clk);
    set_oready(d, 1'b0);
    peek(d, z, ir, ov, co, of);
    check({tag, ".back_to_idle"}, {62'b0, ir, ov}, {62'b0, 1'b1, 1'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] z;
    logic ir, ov, co, of;
    for (int d = 0; d < 3; d++) begin
      drive_in(d, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      set_oready(d, 1'b0);
    end
    // in_valid high during reset must not be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) drive_in(d, 1'b0, 32'b0, 32'b0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      peek(d, z, ir, ov, co, of);
      check($sformatf("reset%0d.flags", d), {60'b0, ir, ov, co, of}, {60'b0, 4'b1000});
      check($sformatf("reset%0d.Z", d), 64'(z), 64'(0));
    end

    run_add(1, 32'h7FFF, 32'h0001, 1'b0, 0, 0, "t1_7fff_plus_1");
    run_add(1, 32'hFFFF, 32'h0001, 1'b0, 1, 0, "t2_ripple");
    run_add(1, 32'h8000, 32'h8000, 1'b1, 0, 1, "t3_cin_ovf");
    run_add(1, 32'h0F0F, 32'h1234, 1'b0, 0, 5, "t4_backpressure");

    // Reset after two RUN nibbles aborts the add.
    drive_in(1, 1'b1, 32'hAAAA, 32'h5555, 1'b1);
    @(negedge clk);
    drive_in(1, 1'b0, 32'b0, 32'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_in(1, 1'b1, 32'h1111, 32'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_in(1, 1'b0, 32'b0, 32'b0, 1'b0);
    peek(1, z, ir, ov, co, of);
    check("t5_abort.flags", {61'b0, ir, ov, co}, {61'b0, 3'b100});
    check("t5_abort.Z", 64'(z), 64'(0));
    repeat (4) begin
      @(negedge clk);
      peek(1, z, ir, ov, co, of);
      check("t5_abort.no_out_valid", 64'(ov), 64'(0));
    end
    run_add(1, 32'h1234, 32'h1111, 1'b0, 0, 0, "t5_after_reset");
    check("t5_after_reset.Z_const", 64'(z16), 64'h2345);

    for (int i = 0; i < 1000; i++) begin
      run_add(0, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), "t6_n4");
    end
    for (int i = 0; i < 1000; i++) begin
      run_add(2, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), "t6_n32");
    end
    run_add(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0, 0, "t6_n32_edge");
    run_add(0, 32'h7, 32'h0, 1'b1, 0, 0, "t6_n4_edge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
